rx_frame_sync: RTL and testbench
================================

# rx_frame_sync

Receive-side frame synchroniser that consumes the serial plaintext stream leaving the dual-XOR stream cipher (`rx_p` qualified by `rx_en`). It hunts for a fixed sync word, assembles the following payload MSB-first into bytes, presents each byte on a valid/ready port, and optionally checks a trailing CRC-8. One instance sits directly downstream of the cipher's receive path.

## Interface
- `SYNC_W`, 16: sync word width in bits (8..32).
- `SYNC_WORD`, 16'hA5C3: sync pattern, MSB received first.
- `PAYLOAD_BYTES`, 4: payload bytes per frame (1..255).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `bit_i`  in  1  serial data bit (cipher `rx_p`).
- `bit_en`  in  1  bit strobe; `bit_i` is sampled only when high (cipher `rx_en`).
- `byte_o`  out  8  assembled payload byte.
- `byte_vld`  out  1  `byte_o` valid; held until accepted.
- `byte_last`  out  1  qualifies `byte_o` as the final payload byte of the frame.
- `byte_rdy`  in  1  consumer accepts when `byte_vld && byte_rdy`.
- `locked`  out  1  high in PAYLOAD or CRC states.
- `frame_ok`  out  1  one-cycle pulse: frame complete and good.
- `frame_err`  out  1  one-cycle pulse: CRC mismatch.
- `ovf`  out  1  sticky: a byte was dropped; cleared only by `rst`.

## Operation
- Reset values: all outputs 0, state HUNT, sync shift register and bit counters cleared, CRC register 0x00.
- States: HUNT -> PAYLOAD -> CRC -> HUNT (CRC state is present only with the macro; otherwise PAYLOAD -> HUNT).
- HUNT: each `bit_en` shifts `bit_i` into an `SYNC_W`-bit register and increments a fill count that saturates at `SYNC_W`. Match requires fill == `SYNC_W` and exact equality, so no match is possible until `SYNC_W` bits have been seen since entering HUNT. On match go to PAYLOAD; clear the bit/byte counters, the CRC register and the fill count.
- PAYLOAD: bits are shifted MSB-first into a byte register; every 8th bit loads the output buffer and increments the byte count. After byte `PAYLOAD_BYTES` go to CRC (or to HUNT with `frame_ok` pulse when CRC is compiled out).
- CRC: collect 8 bits; compare with the computed CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) over all payload bits. Equal -> `frame_ok`, else `frame_err`. Return to HUNT.
- Output buffer is a single register. New byte completes while `byte_vld && !byte_rdy` -> byte dropped, `ovf` set, framing continues. Completion coincident with acceptance -> buffer reloaded, no overflow.
- Payload bytes are delivered before the CRC verdict; the consumer discards the frame on `frame_err`.
- Sync is not searched during PAYLOAD/CRC; there is no false-lock recovery within a frame.
- `bit_en` gaps of any length are allowed; no timeout.

## Timing
- Sync match: `locked` rises the cycle after the `bit_en` that samples the last sync bit.
- Byte: `byte_vld` (and `byte_last` for the last byte) rises the cycle after the `bit_en` sampling the byte's 8th bit; it falls the cycle after acceptance.
- `frame_ok`/`frame_err`: high for exactly the one cycle after the `bit_en` sampling the final frame bit; `locked` falls in the same cycle.
- Back-to-back `bit_en` on every cycle is supported: a new byte completes every 8 cycles.
- `rst` asserted mid-frame forces HUNT immediately. A pending `byte_vld` is dropped; `ovf` is cleared.

## Configuration
- `RX_FRAME_SYNC_CRC_EN` defined: CRC state and trailing CRC-8 byte exist, and `frame_err` is functional.
- Not defined: no CRC byte on the wire, `frame_ok` pulses at end of payload, and `frame_err` is tied 0.

## Structure
- Shared package `rx_frame_sync_pkg`: state enum (HUNT, PAYLOAD, CRC), `CRC8_POLY = 8'h07`, `CRC8_INIT = 8'h00`, and a one-bit CRC-8 next-state function.
- One sub-module, `crc8_serial`, providing a bit-serial CRC register with clear/enable. It is instantiated only under the macro.

## Test plan
- Sync A5C3, payload 01 02 03 04, CRC E3 with `bit_en` every cycle -> four bytes in order, `byte_last` on 04, one `frame_ok` pulse, `frame_err` 0.
- Same frame with CRC E2 -> bytes delivered, `frame_err` pulse, no `frame_ok`.
- Near-miss A5C2 followed by random bits without the true sync -> `locked` stays 0 and no bytes are produced.
- `byte_rdy` held 0 for the whole frame -> byte 01 is held on `byte_o`, bytes 02..04 are dropped, `ovf` is 1 and stays set until `rst`.
- `rst` pulsed after two payload bytes, then a full valid frame -> outputs return to 0, the new frame is received cleanly, and `ovf` is 0.
- Random `bit_en` gaps of 0..5 cycles with `RX_FRAME_SYNC_CRC_EN` undefined -> four bytes received, `frame_ok` follows the 32nd payload bit, and no CRC byte is consumed.

Source files
------------

// File: rtl/rx_frame_sync_pkg.sv
// rtl/rx_frame_sync_pkg.sv - shared states, CRC-8 constants and bit-serial CRC step
package rx_frame_sync_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CRC     = 2'd2
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One input bit of a non-reflected CRC-8, MSB first
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/rx_frame_sync_if.sv
// rtl/rx_frame_sync_if.sv - payload byte valid/ready port
interface rx_frame_sync_if;
  logic [7:0] byte_o;
  logic       byte_vld;
  logic       byte_last;
  logic       byte_rdy;

  modport master (output byte_o, output byte_vld, output byte_last, input byte_rdy);
  modport slave  (input byte_o, input byte_vld, input byte_last, output byte_rdy);
endinterface

// File: rtl/crc8_serial.sv
// rtl/crc8_serial.sv - bit-serial CRC-8 register with clear and enable
import rx_frame_sync_pkg::*;

module crc8_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_i,
  output logic [7:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC8_INIT;
    end else if (clr) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= crc8_next(crc, bit_i);
    end
  end

endmodule

// File: rtl/rx_frame_sync.sv
// rtl/rx_frame_sync.sv - sync hunt, MSB-first byte assembly, optional trailing CRC-8 (RX_FRAME_SYNC_CRC_EN)
import rx_frame_sync_pkg::*;

module rx_frame_sync #(
  parameter int                SYNC_W        = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD     = 16'hA5C3,
  parameter int                PAYLOAD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_i,
  input  logic              bit_en,
  rx_frame_sync_if.master   bus,
  output logic              locked,
  output logic              frame_ok,
  output logic              frame_err,
  output logic              ovf
);

  localparam int                FILL_W    = $clog2(SYNC_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_W);
  localparam logic [7:0]        LAST_IDX  = 8'(PAYLOAD_BYTES - 1);

  state_t            state;
  logic [SYNC_W-1:0] sync_sr;
  logic [FILL_W-1:0] fill;
  logic [2:0]        bit_cnt;
  logic [7:0]        byte_cnt;
  logic [6:0]        byte_sr;
  logic [7:0]        byte_q;
  logic              vld_q;
  logic              last_q;

  logic [SYNC_W-1:0] sync_next;
  logic [FILL_W-1:0] fill_next;
  logic [7:0]        byte_next;
  logic              hit;

  assign sync_next = {sync_sr[SYNC_W-2:0], bit_i};
  assign fill_next = (fill == FILL_FULL) ? fill : fill + 1'b1;
  assign byte_next = {byte_sr, bit_i};
  // Fill gate: a match needs SYNC_W fresh bits since entering HUNT
  assign hit       = (fill_next == FILL_FULL) && (sync_next == SYNC_WORD);

  assign bus.byte_o    = byte_q;
  assign bus.byte_vld  = vld_q;
  assign bus.byte_last = last_q;

`ifdef RX_FRAME_SYNC_CRC_EN
  logic [7:0] crc_val;

  crc8_serial u_crc (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == HUNT),
    .en    ((state == PAYLOAD) && bit_en),
    .bit_i (bit_i),
    .crc   (crc_val)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      sync_sr   <= '0;
      fill      <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      byte_sr   <= '0;
      byte_q    <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      locked    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (vld_q && bus.byte_rdy) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end

      case (state)
        HUNT: begin
          if (bit_en) begin
            sync_sr <= sync_next;
            if (hit) begin
              state    <= PAYLOAD;
              locked   <= 1'b1;
              fill     <= '0;
              bit_cnt  <= '0;
              byte_cnt <= '0;
            end else begin
              fill <= fill_next;
            end
          end
        end

        PAYLOAD: begin
          if (bit_en) begin
            byte_sr <= byte_next[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_cnt <= byte_cnt + 8'd1;
              // Buffer is free if empty or being accepted this very cycle
              if (!vld_q || bus.byte_rdy) begin
                byte_q <= byte_next;
                vld_q  <= 1'b1;
                last_q <= (byte_cnt == LAST_IDX);
              end else begin
                ovf <= 1'b1;
              end
              if (byte_cnt == LAST_IDX) begin
`ifdef RX_FRAME_SYNC_CRC_EN
                state    <= CRC;
`else
                state    <= HUNT;
                locked   <= 1'b0;
                frame_ok <= 1'b1;
`endif
              end
            end
          end
        end

        CRC: begin
`ifdef RX_FRAME_SYNC_CRC_EN
          if (bit_en) begin
            byte_sr <= byte_next[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state  <= HUNT;
              locked <= 1'b0;
              if (byte_next == crc_val) frame_ok  <= 1'b1;
              else                      frame_err <= 1'b1;
            end
          end
`else
          state <= HUNT;
`endif
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_sync.sv
// tb/tb_rx_frame_sync.sv - self-checking bench for rx_frame_sync
module tb_rx_frame_sync;

  logic clk = 1'b0;
  logic rst;
  logic bit_i;
  logic bit_en;
  logic locked, frame_ok, frame_err, ovf;

  rx_frame_sync_if bus ();

  rx_frame_sync dut (
    .clk       (clk),
    .rst       (rst),
    .bit_i     (bit_i),
    .bit_en    (bit_en),
    .bus       (bus),
    .locked    (locked),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef struct {
    logic [15:0] pre;
    int          pre_len;
    logic [31:0] payload;
    int          gmax;
    logic        crc_bad;
  } vec_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   ok_cnt  = 0;
  int   err_cnt = 0;
  int   exp_ok  = 0;
  int   exp_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_crc(input logic [31:0] p);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      if (c[7] ^ p[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.byte_vld && bus.byte_rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_byte", 32'(bus.byte_o), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("byte_data", 32'(bus.byte_o), 32'(e.data));
          check("byte_last", 32'(bus.byte_last), 32'(e.last));
        end
      end
      if (frame_ok)  ok_cnt++;
      if (frame_err) err_cnt++;
    end
  end

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      bit_en = 1'b0;
      @(posedge clk);
      #1;
    end
    bit_i  = b;
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input int gmax);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], int'($urandom_range(gmax, 0)));
  endtask

  task automatic send_sync(input int gmax);
    send_bits(32'h0000_A5C3 >> 1, 15, gmax);
    check("locked_before_last_sync_bit", 32'(locked), 32'h0);
    send_bit(1'b1, int'($urandom_range(gmax, 0)));
    check("locked_after_sync", 32'(locked), 32'h1);
  endtask

  task automatic send_payload(input logic [31:0] p, input int n, input int gmax, input logic first_only);
    logic [7:0] b;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      b = p[31 - 8*k -: 8];
      for (int j = 7; j >= 0; j--) begin
        if (j == 0 && (!first_only || k == 0)) begin
          e.data = b;
          e.last = (k == 3);
          sb.push_back(e);
        end
        send_bit(b[j], int'($urandom_range(gmax, 0)));
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] p, input int gmax, input logic crc_bad, input logic first_only);
    send_sync(gmax);
    send_payload(p, 4, gmax, first_only);
`ifdef RX_FRAME_SYNC_CRC_EN
    check("locked_before_crc", 32'(locked), 32'h1);
    check("no_ok_before_crc", 32'(frame_ok), 32'h0);
    send_bits(32'(tb_crc(p) ^ {7'b0, crc_bad}), 8, gmax);
    check("frame_ok_pulse", 32'(frame_ok), 32'(!crc_bad));
    check("frame_err_pulse", 32'(frame_err), 32'(crc_bad));
    if (crc_bad) exp_err++;
    else         exp_ok++;
`else
    check("frame_ok_pulse", 32'(frame_ok), 32'h1);
    check("frame_err_pulse", 32'(frame_err), 32'h0);
    exp_ok++;
`endif
    check("locked_end", 32'(locked), 32'h0);
    @(posedge clk);
    #1;
    check("frame_ok_one_cycle", 32'(frame_ok), 32'h0);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("sb_drain", 32'(sb.size()), 32'h0);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bit_en       = 1'b0;
    bit_i        = 1'b0;
    bus.byte_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [4];
    logic [15:0] win;
    logic        b;
    logic        saw_lock;

    tbl[0] = '{16'h005A, 8,  32'hDEADBEEF, 5, 1'b0};
    tbl[1] = '{16'h0000, 0,  32'h01020304, 0, 1'b0};
    tbl[2] = '{16'hFFFF, 16, 32'h00FF8001, 2, 1'b0};
    tbl[3] = '{16'h0000, 3,  32'h7E817E81, 1, 1'b1};

    do_reset();
    check("rst_byte_o", 32'(bus.byte_o), 32'h0);
    check("rst_byte_vld", 32'(bus.byte_vld), 32'h0);
    check("rst_byte_last", 32'(bus.byte_last), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_frame_ok", 32'(frame_ok), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);

    for (int i = 0; i < 4; i++) begin
      send_bits(32'(tbl[i].pre), tbl[i].pre_len, tbl[i].gmax);
      check("locked_in_hunt", 32'(locked), 32'h0);
      send_frame(tbl[i].payload, tbl[i].gmax, tbl[i].crc_bad, 1'b0);
      wait_drain();
      check("ovf_clear", 32'(ovf), 32'h0);
    end

    // Near-miss sync followed by random bits that never form the real sync word
    do_reset();
    send_bits(32'h0000_A5C2, 16, 0);
    win      = 16'hA5C2;
    saw_lock = locked;
    for (int i = 0; i < 80; i++) begin
      b = 1'($urandom_range(1, 0));
      if ({win[14:0], b} == 16'hA5C3) b = ~b;
      win = {win[14:0], b};
      send_bit(b, 0);
      if (locked) saw_lock = 1'b1;
    end
    check("near_miss_locked", 32'(saw_lock), 32'h0);
    check("near_miss_no_byte", 32'(bus.byte_vld), 32'h0);

    // Consumer stalled for a whole frame: first byte held, rest dropped
    do_reset();
    bus.byte_rdy = 1'b0;
    send_frame(32'h01020304, 0, 1'b0, 1'b1);
    check("stall_byte_o", 32'(bus.byte_o), 32'h01);
    check("stall_byte_vld", 32'(bus.byte_vld), 32'h1);
    check("stall_byte_last", 32'(bus.byte_last), 32'h0);
    check("stall_ovf", 32'(ovf), 32'h1);
    bus.byte_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("stall_vld_fall", 32'(bus.byte_vld), 32'h0);
    check("stall_sb_empty", 32'(sb.size()), 32'h0);
    send_frame(32'hC0FFEE11, 1, 1'b0, 1'b0);
    wait_drain();
    check("ovf_sticky", 32'(ovf), 32'h1);

    // Reset in mid-frame, then a clean frame
    send_sync(0);
    send_payload(32'hAABBCCDD, 2, 0, 1'b0);
    wait_drain();
    send_bits(32'h5, 3, 0);
    rst = 1'b1;
    #2;
    check("midrst_locked", 32'(locked), 32'h0);
    check("midrst_vld", 32'(bus.byte_vld), 32'h0);
    check("midrst_ovf", 32'(ovf), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(32'h01020304, 0, 1'b0, 1'b0);
    wait_drain();
    check("after_rst_ovf", 32'(ovf), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("frame_ok_count", 32'(ok_cnt), 32'(exp_ok));
    check("frame_err_count", 32'(err_cnt), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
